// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry_ctrl
// Purpose  : Sits between the raw keypad push-buttons and the charbuf
//            hex-character buffer. Keys are synchronised and debounced, then
//            classified as digit, backspace, clear or enter. Each accepted
//            press produces exactly one single-cycle charbuf command. The
//            block tracks how full the buffer is, and on enter it copies the
//            buffer contents into a result register.
// Ports    : clk, rst (async, active high)
//            key_i[18:0]    raw keys: [15:0] hex 0-F, [16] bksp, [17] clr,
//                           [18] enter
//            cb_out_i       charbuf contents; cb_is_empty_i is the charbuf
//                           empty flag
//            cb_enable_o, cb_clr_o, cb_bksp_o, cb_is_ctrl_o, cb_char_o
//                           charbuf command outputs, all registered
//            count_o        characters held; value_o holds the last
//                           committed contents
//            valid_o / overflow_o / timeout_o  one-cycle pulses
// Options  : TIMEOUT_CLR_EN  when defined, the buffer is auto-cleared after
//                            TIMEOUT idle cycles
// Revision : 1.0  initial release
// ============================================================================
module keypad_entry_ctrl #(
  parameter int DEBOUNCE   = 4,
  parameter int MAX_DIGITS = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [18:0]             key_i,
  input  logic [4*MAX_DIGITS-1:0] cb_out_i,
  input  logic                    cb_is_empty_i,
  output logic                    cb_enable_o,
  output logic                    cb_clr_o,
  output logic                    cb_bksp_o,
  output logic                    cb_is_ctrl_o,
  output logic [3:0]              cb_char_o,
  output logic [3:0]              count_o,
  output logic [4*MAX_DIGITS-1:0] value_o,
  output logic                    valid_o,
  output logic                    overflow_o,
  output logic                    timeout_o
);

  localparam int             DW    = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0]  C_DEB = DW'(DEBOUNCE);
  localparam logic [3:0]     C_MAX = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEB      = 2'd1,
    FIRE     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [18:0]             sync1_q, ks_q;
  logic [18:0]             snap_q, snap_d;
  logic [DW-1:0]           dcnt_q, dcnt_d;
  logic [3:0]              count_q, count_d;
  logic                    en_q, en_d, clr_q, clr_d, bksp_q, bksp_d;
  logic                    ctrl_q, ctrl_d, ovf_q, ovf_d;
  logic [3:0]              char_q, char_d;
  logic                    commit_q, commit_d;
  logic [4*MAX_DIGITS-1:0] value_q, value_d;
  logic                    valid_q, valid_d;
  logic [3:0]              digit;

  // The lowest-index digit wins, so scan from the top down.
  always_comb begin
    digit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (snap_q[i]) digit = 4'(i);
    end
  end

`ifdef TIMEOUT_CLR_EN
  localparam int            IW     = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] C_TOM1 = IW'(TIMEOUT - 1);
  logic [IW-1:0] icnt_q, icnt_d;
  logic          tmo_q, tmo_d;
  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    dcnt_d   = dcnt_q;
    count_d  = count_q;
    en_d     = 1'b0;
    clr_d    = 1'b0;
    bksp_d   = 1'b0;
    ctrl_d   = 1'b0;
    char_d   = 4'd0;
    ovf_d    = 1'b0;
    commit_d = 1'b0;
    // Capture at the edge that ends FIRE, while charbuf still holds the
    // contents it had before the clear.
    valid_d  = commit_q;
    value_d  = commit_q ? cb_out_i : value_q;

    // During FIRE the charbuf flags still show the state before the command
    // we just issued, so the resync only runs outside FIRE.
    if (state_q != FIRE && cb_is_empty_i && count_q != 4'd0) count_d = 4'd0;

    case (state_q)
      IDLE: begin
        if (ks_q != 19'd0) begin
          state_d = DEB;
          dcnt_d  = DW'(1);
          snap_d  = ks_q;
        end
      end
      DEB: begin
        if (ks_q == 19'd0) begin
          state_d = IDLE;
        end else if (ks_q != snap_q) begin
          dcnt_d = DW'(1);
          snap_d = ks_q;
        end else if (dcnt_q == C_DEB) begin
          state_d = FIRE;
          // Command registers load here so they are high during FIRE only.
          if (snap_q[17]) begin
            clr_d   = 1'b1;
            count_d = 4'd0;
          end else if (snap_q[16]) begin
            if (count_q != 4'd0) begin
              en_d    = 1'b1;
              bksp_d  = 1'b1;
              ctrl_d  = 1'b1;
              count_d = count_q - 4'd1;
            end
          end else if (snap_q[18]) begin
            if (count_q != 4'd0) begin
              clr_d    = 1'b1;
              commit_d = 1'b1;
              count_d  = 4'd0;
            end
          end else if (count_q < C_MAX) begin
            en_d    = 1'b1;
            char_d  = digit;
            count_d = count_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      FIRE:     state_d = WAIT_REL;
      WAIT_REL: if (ks_q == 19'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

`ifdef TIMEOUT_CLR_EN
  // The idle counter runs only while waiting in IDLE with characters held.
  // An arriving press takes priority and zeroes the counter.
  always_comb begin
    icnt_d = '0;
    tmo_d  = 1'b0;
    if (state_q == IDLE && ks_q == 19'd0 && count_q != 4'd0) begin
      if (icnt_q == C_TOM1) begin
        tmo_d = 1'b1;
      end else begin
        icnt_d = icnt_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      icnt_q <= icnt_d;
      tmo_q  <= tmo_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      ks_q     <= '0;
      state_q  <= IDLE;
      snap_q   <= '0;
      dcnt_q   <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      bksp_q   <= 1'b0;
      ctrl_q   <= 1'b0;
      char_q   <= '0;
      ovf_q    <= 1'b0;
      commit_q <= 1'b0;
      value_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= key_i;
      ks_q     <= sync1_q;
      state_q  <= state_d;
      snap_q   <= snap_d;
      dcnt_q   <= dcnt_d;
      en_q     <= en_d;
      bksp_q   <= bksp_d;
      ctrl_q   <= ctrl_d;
      char_q   <= char_d;
      ovf_q    <= ovf_d;
      commit_q <= commit_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
`ifdef TIMEOUT_CLR_EN
      count_q  <= tmo_d ? 4'd0 : count_d;
      clr_q    <= clr_d | tmo_d;
`else
      count_q  <= count_d;
      clr_q    <= clr_d;
`endif
    end
  end

  assign cb_enable_o  = en_q;
  assign cb_clr_o     = clr_q;
  assign cb_bksp_o    = bksp_q;
  assign cb_is_ctrl_o = ctrl_q;
  assign cb_char_o    = char_q;
  assign count_o      = count_q;
  assign value_o      = value_q;
  assign valid_o      = valid_q;
  assign overflow_o   = ovf_q;

endmodule
`default_nettype wire
